// File: rtl/ma_ctrl.sv
// ma_ctrl -- sequencing controller for one 8-deep moving-average filter.
//
// Latches ADC samples into the filter data register, flushes the filter on
// start and on any decimation change, issues one-cycle sample strobes every
// div_val+1 cycles, and captures filter results into a ready/valid output
// register with a sticky overflow flag for results that had to be dropped.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-low reset
//   enable           1 = run, 0 = return to IDLE
//   div_val          strobe period minus 1 (clk cycles)
//   adc_valid        qualifies adc_data
//   adc_data         raw ADC sample
//   filt_reset_n     registered active-low reset to the filter
//   filt_sample      one-cycle sample strobe to the filter
//   filt_data        sample presented to the filter
//   filt_data_out    filter average
//   filt_data_rdy    filter window full
//   filt_sample_out  filter one-cycle result pulse
//   out_data         captured average
//   out_valid        out_data valid
//   out_ready        consumer accepts out_data
//   overflow         sticky: a result was dropped
//   clr_ovf          clears overflow
//   state            00 IDLE, 01 FLUSH, 10 FILL, 11 RUN
module ma_ctrl #(
  parameter int IWIDTH       = 10,
  parameter int OWIDTH       = IWIDTH,
  parameter int DIV_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 adc_valid,
  input  logic [IWIDTH-1:0]    adc_data,
  output logic                 filt_reset_n,
  output logic                 filt_sample,
  output logic [IWIDTH-1:0]    filt_data,
  input  logic [OWIDTH-1:0]    filt_data_out,
  input  logic                 filt_data_rdy,
  input  logic                 filt_sample_out,
  output logic [OWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  input  logic                 clr_ovf,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FLUSH = 2'b01,
    S_FILL  = 2'b10,
    S_RUN   = 2'b11
  } state_t;

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_flush_load;
  logic [FCW-1:0]       r_flush_cnt;
  logic [DIV_WIDTH-1:0] r_div_shadow;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_filt_reset_n;
  logic                 r_filt_sample;
  logic [IWIDTH-1:0]    r_filt_data;
  logic [OWIDTH-1:0]    r_out_data;
  logic                 r_out_valid;
  logic                 r_overflow;
  logic                 w_strobing;
  logic                 w_active_nxt;
  logic                 w_result;
  logic                 w_capture;
  logic                 w_ovf_evt;

  // Next state. Outside IDLE, dropping enable beats everything; a div_val
  // change (re)starts the flush so the new period is only used after it.
  always_comb begin
    w_state_nxt  = r_state;
    w_flush_load = 1'b0;
    if (r_state == S_IDLE) begin
      if (enable) begin
        w_state_nxt  = S_FLUSH;
        w_flush_load = 1'b1;
      end
    end else if (!enable) begin
      w_state_nxt = S_IDLE;
    end else if (div_val != r_div_shadow) begin
      w_state_nxt  = S_FLUSH;
      w_flush_load = 1'b1;
    end else begin
      case (r_state)
        S_FLUSH: if (r_flush_cnt == FLUSH_LAST) w_state_nxt = S_FILL;
        S_FILL:  if (filt_data_rdy) w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_strobing   = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_active_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);

  // A result can only be taken in RUN; it is dropped if the held one is unread.
  assign w_result  = (r_state == S_RUN) && filt_sample_out;
  assign w_capture = w_result && (!r_out_valid || out_ready);
  assign w_ovf_evt = w_result && r_out_valid && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_flush_cnt    <= '0;
      r_div_shadow   <= '0;
      r_div_cnt      <= '0;
      r_filt_reset_n <= 1'b0;
      r_filt_sample  <= 1'b0;
      r_filt_data    <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      // Filter reset follows the state being entered so it releases in the
      // first FILL cycle and asserts on the edge that leaves FILL/RUN.
      r_filt_reset_n <= w_active_nxt;

      if (adc_valid) r_filt_data <= adc_data;

      // Divider: strobe when the count is 0, but never on an edge that
      // leaves FILL/RUN.
      r_filt_sample <= w_strobing && w_active_nxt && (r_div_cnt == '0);
      if (w_strobing) begin
        if (r_div_cnt == '0) r_div_cnt <= r_div_shadow;
        else                 r_div_cnt <= r_div_cnt - 1'b1;
      end

      if (w_flush_load) begin
        r_flush_cnt  <= '0;
        r_div_shadow <= div_val;
        r_div_cnt    <= div_val;
      end else if (r_state == S_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end

      if (w_capture) begin
        r_out_data  <= filt_data_out;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A new drop in the same cycle as clr_ovf keeps the flag set.
      r_overflow <= w_ovf_evt || (r_overflow && !clr_ovf);
    end
  end

  assign filt_reset_n = r_filt_reset_n;
  assign filt_sample  = r_filt_sample;
  assign filt_data    = r_filt_data;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign overflow     = r_overflow;
  assign state        = r_state;

endmodule

// File: tb/tb_ma_ctrl.sv
// Directed bench for ma_ctrl with a behavioural 8-deep moving-average filter
// attached and a scoreboard of expected captured results.
module tb_ma_ctrl;

  localparam int IWIDTH    = 10;
  localparam int OWIDTH    = IWIDTH;
  localparam int DIV_WIDTH = 16;
  localparam int FLUSH_CYC = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_FILL  = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic [DIV_WIDTH-1:0] div_val;
  logic                 adc_valid;
  logic [IWIDTH-1:0]    adc_data;
  logic                 filt_reset_n;
  logic                 filt_sample;
  logic [IWIDTH-1:0]    filt_data;
  logic [OWIDTH-1:0]    filt_data_out;
  logic                 filt_data_rdy;
  logic                 filt_sample_out;
  logic [OWIDTH-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic                 clr_ovf;
  logic [1:0]           state;

  ma_ctrl #(
    .IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .DIV_WIDTH(DIV_WIDTH), .FLUSH_CYCLES(FLUSH_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_val(div_val),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .filt_reset_n(filt_reset_n), .filt_sample(filt_sample), .filt_data(filt_data),
    .filt_data_out(filt_data_out), .filt_data_rdy(filt_data_rdy),
    .filt_sample_out(filt_sample_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moving-average filter model: result pulse one cycle after each strobe
  // once 8 samples have been taken.
  logic [IWIDTH-1:0] win [8];
  int                fcnt;
  int                m_sum;
  logic [OWIDTH-1:0] m_out;
  logic              m_rdy;
  logic              m_pulse;

  assign filt_data_out   = m_out;
  assign filt_data_rdy   = m_rdy;
  assign filt_sample_out = m_pulse;

  always @(posedge clk) begin
    if (filt_reset_n !== 1'b1) begin
      for (int k = 0; k < 8; k++) win[k] <= '0;
      fcnt    <= 0;
      m_rdy   <= 1'b0;
      m_pulse <= 1'b0;
      m_out   <= '0;
    end else begin
      m_pulse <= 1'b0;
      if (filt_sample === 1'b1) begin
        m_sum = int'(filt_data);
        for (int k = 0; k < 7; k++) begin
          win[k+1] <= win[k];
          m_sum = m_sum + int'(win[k]);
        end
        win[0] <= filt_data;
        if (fcnt < 8) fcnt <= fcnt + 1;
        if (fcnt >= 7) begin
          m_rdy   <= 1'b1;
          m_pulse <= 1'b1;
          m_out   <= OWIDTH'(m_sum / 8);
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  logic [OWIDTH-1:0] sb_q[$];
  logic              sb_on   = 1'b0;
  logic              exp_run = 1'b0;
  logic              exp_vld = 1'b0;
  logic              exp_ovf = 1'b0;
  logic [OWIDTH-1:0] last_cap = '0;
  int                n_strb  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict the output register from the stimulus, advance, then
  // compare just after the edge.
  task automatic tick();
    logic pulse;
    logic cap;
    logic ovf_evt;
    pulse   = sb_on && exp_run && (m_pulse === 1'b1);
    cap     = pulse && (!exp_vld || out_ready);
    ovf_evt = pulse && exp_vld && !out_ready;
    if (sb_on) begin
      if (cap) begin
        sb_q.push_back(m_out);
        exp_vld = 1'b1;
      end else if (out_ready) begin
        exp_vld = 1'b0;
      end
      if (ovf_evt)      exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    if (filt_sample === 1'b1) n_strb++;
    if (sb_on) begin
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (cap) begin
        last_cap = sb_q.pop_front();
        chk("out_data", 32'(out_data), 32'(last_cap));
      end
    end
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 20 && m_pulse !== 1'b1; i++) tick();
    chk("pulse_seen", 32'(m_pulse), 32'd1);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && state !== ST_RUN; i++) tick();
    chk("reach_run", 32'(state), 32'(ST_RUN));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    chk({tag, "_frst"},  32'(filt_reset_n), 32'd0);
    chk({tag, "_fsmp"},  32'(filt_sample), 32'd0);
    chk({tag, "_fdat"},  32'(filt_data), 32'd0);
    chk({tag, "_odat"},  32'(out_data), 32'd0);
    chk({tag, "_ovld"},  32'(out_valid), 32'd0);
    chk({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  logic [OWIDTH-1:0] kept;

  initial begin
    reset = 1'b0; enable = 1'b0; div_val = '0; adc_valid = 1'b0; adc_data = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");

    // Start with div_val=3 and a constant 100 input.
    reset = 1'b1; div_val = 16'd3; adc_valid = 1'b1; adc_data = 10'd100;
    sb_on = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'(ST_IDLE));
    chk("fdat_load", 32'(filt_data), 32'd100);
    adc_valid = 1'b0; adc_data = 10'd55; enable = 1'b1;
    tick();
    chk("fdat_hold", 32'(filt_data), 32'd100);
    adc_valid = 1'b1; adc_data = 10'd100;
    chk("flush_st", 32'(state), 32'(ST_FLUSH));
    chk("flush_rst", 32'(filt_reset_n), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_st", 32'(state), 32'(ST_FLUSH));
      chk("flush_rst", 32'(filt_reset_n), 32'd0);
    end
    tick();
    chk("fill_st", 32'(state), 32'(ST_FILL));
    chk("fill_rst", 32'(filt_reset_n), 32'd1);
    chk("fill_nostrb", 32'(filt_sample), 32'd0);
    n_strb = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("strb_low", 32'(filt_sample), 32'd0);
      end
      tick();
      chk("strb_high", 32'(filt_sample), 32'd1);
    end

    // Eight strobes fill the window; RUN follows data_rdy.
    wait_run();
    chk("strobes_to_run", 32'(n_strb), 32'd8);
    chk("run_vld0", 32'(out_valid), 32'd0);
    exp_run = 1'b1;

    // Normal capture and drain.
    out_ready = 1'b1;
    wait_pulse();
    tick();
    chk("avg100", 32'(out_data), 32'd100);
    chk("cap_vld", 32'(out_valid), 32'd1);
    tick();
    chk("vld_clear", 32'(out_valid), 32'd0);
    repeat (8) tick();

    // Consumer stalls: later results are dropped and flagged.
    out_ready = 1'b0; adc_data = 10'd200;
    repeat (12) tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    kept = last_cap;
    chk("ovf_keep", 32'(out_data), 32'(kept));

    // clr_ovf coinciding with a drop: set wins; alone it clears.
    wait_pulse();
    clr_ovf = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_keep2", 32'(out_data), 32'(kept));
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Capture with out_ready in the same cycle keeps out_valid high.
    wait_pulse();
    out_ready = 1'b1;
    tick();
    chk("cap_rdy_vld", 32'(out_valid), 32'd1);
    chk("cap_rdy_new", 32'(out_data != kept), 32'd1);
    tick();
    chk("cap_rdy_drain", 32'(out_valid), 32'd0);

    // div_val change in RUN reflushes, then strobes every cycle.
    div_val = 16'd0;
    tick();
    exp_run = 1'b0;
    chk("chg_flush", 32'(state), 32'(ST_FLUSH));
    chk("chg_rst", 32'(filt_reset_n), 32'd0);
    chk("chg_nostrb", 32'(filt_sample), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("chg_flush", 32'(state), 32'(ST_FLUSH));
    end
    tick();
    chk("chg_fill", 32'(state), 32'(ST_FILL));
    chk("chg_fill_strb", 32'(filt_sample), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div0_strb", 32'(filt_sample), 32'd1);
    end

    // enable falls during FILL.
    enable = 1'b0;
    tick();
    chk("dis_idle", 32'(state), 32'(ST_IDLE));
    chk("dis_rst", 32'(filt_reset_n), 32'd0);
    chk("dis_nostrb", 32'(filt_sample), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_nostrb", 32'(filt_sample), 32'd0);
    end

    // Async reset in RUN with a result pending.
    enable = 1'b1; out_ready = 1'b0;
    wait_run();
    exp_run = 1'b1;
    wait_pulse();
    tick();
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    sb_on = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ma_ctrl.md
# ma_ctrl

Sequencing controller for one moving-average filter instance, which has 8-sample depth and an active-low asynchronous reset. It latches incoming ADC samples and issues filter sample strobes at a programmable decimation rate. It flushes the filter on start and on any configuration change, then captures averaged results into a ready/valid output register with sticky overflow reporting. It sits between the ADC capture logic and the downstream consumer of averaged data.

## Interface
- IWIDTH, 10, width of ADC sample and filter data_in
- OWIDTH, IWIDTH, width of filter data_out and out_data
- DIV_WIDTH, 16, width of decimation divider
- FLUSH_CYCLES, 4, cycles the filter reset is held low per flush (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = run controller, 0 = return to IDLE
- div_val  in  DIV_WIDTH  strobe period minus 1, in clk cycles
- adc_valid  in  1  qualifies adc_data
- adc_data  in  IWIDTH  raw sample
- filt_reset_n  out  1  registered active-low reset to filter
- filt_sample  out  1  one-cycle sample strobe to filter sample_in
- filt_data  out  IWIDTH  to filter data_in, stable whenever filt_sample=1
- filt_data_out  in  OWIDTH  filter average output
- filt_data_rdy  in  1  filter window full
- filt_sample_out  in  1  filter one-cycle result pulse
- out_data  out  OWIDTH  captured average
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- overflow  out  1  sticky: result dropped
- clr_ovf  in  1  clears overflow
- state  out  2  00 IDLE, 01 FLUSH, 10 FILL, 11 RUN

## Operation
- Reset values: state=IDLE, filt_reset_n=0, filt_sample=0, filt_data=0, out_data=0, out_valid=0, overflow=0, divider count=0, flush count=0, div_val shadow=0.
- filt_data register: loads adc_data on every cycle where adc_valid=1, in any state.
- IDLE:
  - filt_reset_n=0 and no strobes.
  - enable=1 → FLUSH.
- FLUSH:
  - filt_reset_n=0 for exactly FLUSH_CYCLES cycles.
  - Captures div_val into the shadow and loads the divider with div_val.
  - Then → FILL.
- FILL:
  - filt_reset_n=1.
  - Divider decrements each cycle. At 0 it pulses filt_sample and reloads from the shadow.
  - filt_data_rdy=1 → RUN.
- RUN:
  - Divider and strobes continue as in FILL.
  - Results are captured (see below).
- Priority, applied in every state except IDLE:
  - enable=0 → IDLE; wins over everything else.
  - Otherwise, div_val ≠ shadow → FLUSH; the flush count restarts.
- Capture, in RUN only: filt_sample_out=1 loads out_data from filt_data_out and sets out_valid on the next edge, provided out_valid=0 or out_ready=1 in that cycle.
- Overflow: if filt_sample_out=1 while out_valid=1 and out_ready=0, the new result is dropped, out_data is unchanged and overflow is set.
- Output handshake:
  - out_valid clears when out_ready=1 and there is no simultaneous capture.
  - Capture and out_ready in the same cycle: out_valid stays 1 and out_data takes the new value.
- clr_ovf clears overflow. If it coincides with a new overflow event, set wins.
- Leaving RUN (to IDLE or FLUSH) does not clear out_valid or out_data; a pending result still drains through the handshake.
- Divider width rule: div_val=0 means a strobe every cycle. Maximum period is 2^DIV_WIDTH cycles.

## Timing
- Every output is registered; no combinational path from input to output.
- enable rising: state=FLUSH on the next edge, and filt_reset_n is low for FLUSH_CYCLES cycles.
- Entry to FILL:
  - filt_reset_n=1 in the first FILL cycle.
  - First filt_sample is asserted div_val+1 cycles after FILL entry.
  - Strobes then repeat every div_val+1 cycles.
- FILL→RUN occurs on the edge after filt_data_rdy is first seen high.
- Result latency: out_valid rises 1 cycle after filt_sample_out.
- enable falling: state=IDLE and filt_reset_n=0 on the next edge. No strobe is issued on that edge.
- A div_val change takes effect on the strobe period only after the flush completes.
- A reset assertion mid-operation forces all reset values immediately (asynchronously).

## Test plan
- Reset, then enable=1 with div_val=3 and FLUSH_CYCLES=4 → filt_reset_n low for 4 cycles, then first filt_sample 4 cycles into FILL, then strobes every 4 cycles.
- Constant adc_data=100 with the filter model attached → state reaches RUN after 8 strobes; each filt_sample_out gives out_data=100 one cycle later; out_ready=1 clears out_valid.
- out_ready=0 held across two filt_sample_out pulses → first result retained, overflow=1; clr_ovf=1 → overflow=0; capture with out_ready=1 in the same cycle → out_data updated and out_valid stays 1.
- Change div_val 3→0 in RUN → state=FLUSH next edge; after 4 cycles FILL; strobes every cycle.
- enable=0 during FILL → IDLE next edge, filt_reset_n=0, no further strobes. Async reset mid-RUN → all outputs at reset values immediately.
